// File: rtl/echo_pulse_timer_if.sv
// echo_pulse_timer_if: sensor-side and averager-side signals of the echo front end
interface echo_pulse_timer_if;
    logic        enable;
    logic        echo;
    logic        trig;
    logic [15:0] width;
    logic        width_valid;
    logic        timeout;
    logic        busy;

    modport master (
        output enable, echo,
        input  trig, width, width_valid, timeout, busy
    );

    modport slave (
        input  enable, echo,
        output trig, width, width_valid, timeout, busy
    );
endinterface

// File: rtl/echo_pulse_timer.sv
// echo_pulse_timer: periodic trigger generation and echo high-time measurement
module echo_pulse_timer #(
    parameter int TRIG_CYCLES    = 22,
    parameter int BLANK_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int PERIOD_CYCLES  = 262144
) (
    input  logic              osc_clk,
    input  logic              rst_n,
    echo_pulse_timer_if.slave bus
);
    localparam int PW   = $clog2(PERIOD_CYCLES);
    localparam int CMAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, TRIG, BLANK, ARM, MEASURE, HOLDOFF} state_t;

    state_t          r_state, w_next;
    logic            r_sync, r_echo_s, r_echo_d;
    logic            w_rise, w_fall, w_boundary, w_timeout;
    logic [PW-1:0]   r_period;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_wcnt, r_width;
    logic            r_width_valid;

    assign w_rise     = r_echo_s & ~r_echo_d;
    assign w_fall     = ~r_echo_s & r_echo_d;
    assign w_boundary = r_period == PW'(PERIOD_CYCLES - 1);

    assign bus.trig        = r_state == TRIG;
    assign bus.busy        = r_state != IDLE;
    assign bus.width       = r_width;
    assign bus.width_valid = r_width_valid;
    assign bus.timeout     = w_timeout;

    // Two-flop synchroniser plus a delay flop for edge detection
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 1'b0;
            r_echo_s <= 1'b0;
            r_echo_d <= 1'b0;
        end else begin
            r_sync   <= bus.echo;
            r_echo_s <= r_sync;
            r_echo_d <= r_echo_s;
        end
    end

    // State register
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state; a rise beats the wait timeout and a fall beats the period boundary
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:    if (bus.enable) w_next = TRIG;
            TRIG:    if (r_cnt == CW'(TRIG_CYCLES - 1)) w_next = BLANK;
            BLANK:   if (r_cnt == CW'(BLANK_CYCLES - 1)) w_next = ARM;
            ARM: begin
                if (w_rise) w_next = MEASURE;
                else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
                    w_next    = HOLDOFF;
                    w_timeout = 1'b1;
                end
            end
            MEASURE: begin
                if (w_boundary) begin
                    w_next    = TRIG;
                    w_timeout = ~w_fall;
                end else if (w_fall) w_next = HOLDOFF;
            end
            HOLDOFF: if (w_boundary) w_next = bus.enable ? TRIG : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Phase counter: trigger length in TRIG, then the wait since trigger fall through BLANK and ARM
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= ((w_next == r_state || r_state == BLANK) && r_state inside {TRIG, BLANK, ARM})
                             ? r_cnt + CW'(1) : '0;
    end

    // Ping period counter, held at zero in IDLE so the first ping starts at count 0
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) r_period <= '0;
        else        r_period <= (r_state == IDLE || w_boundary) ? '0 : r_period + PW'(1);
    end

    // Width counter counts cycles of echo_s high, including the rise cycle, saturating
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) r_wcnt <= '0;
        else if (r_state == ARM && w_rise) r_wcnt <= 16'd1;
        else if (r_state == MEASURE && r_echo_s && r_wcnt != 16'hFFFF) r_wcnt <= r_wcnt + 16'd1;
    end

    // Publish the width and its strobe on the falling edge of the echo
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width       <= '0;
            r_width_valid <= 1'b0;
        end else begin
            r_width_valid <= r_state == MEASURE && w_fall;
            if (r_state == MEASURE && w_fall) r_width <= r_wcnt;
        end
    end
endmodule

// File: tb/tb_echo_pulse_timer.sv
// tb_echo_pulse_timer: ping-by-ping echo stimulus table with a strobe scoreboard
module tb_echo_pulse_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    echo_pulse_timer_if bus();

    echo_pulse_timer #(
        .TRIG_CYCLES   (22),
        .BLANK_CYCLES  (8),
        .TIMEOUT_CYCLES(600),
        .PERIOD_CYCLES (1000)
    ) dut (
        .osc_clk(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // One ping: raw echo high for ping cycles [a1,b1) and [a2,b2), enable dropped at cycle drop,
    // expecting a timeout (tmo) or a width w at ping cycle exp_at
    typedef struct {
        int a1; int b1; int a2; int b2; int drop;
        bit tmo; int w; int exp_at;
    } ping_t;

    typedef struct {
        bit tmo; int w; int exp_at;
    } exp_t;

    exp_t  q[$];
    ping_t tbl[10];
    int    n_checks = 0;
    int    n_fail = 0;
    int    mw = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (bus.width_valid || bus.timeout) begin
            chk("strobe_exclusive", int'(bus.width_valid & bus.timeout), 0);
            if (q.size() == 0) chk("unexpected_strobe", int'(bus.width_valid | bus.timeout), 0);
            else begin
                e = q.pop_front();
                chk("event_kind", int'(bus.timeout), int'(e.tmo));
                chk("event_cycle", cyc, e.exp_at);
                if (bus.width_valid) mw = e.w;
                chk("event_width", int'(bus.width), mw);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    // Called at ping cycle 0; returns at ping cycle 0 of the following period
    task automatic run_ping(input ping_t p);
        int   base;
        int   th;
        exp_t e;
        base = cyc;
        th = 0;
        e.tmo = p.tmo;
        e.w = p.w;
        e.exp_at = base + p.exp_at;
        q.push_back(e);
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) tick();
            bus.echo = (k >= p.a1 && k < p.b1) || (k >= p.a2 && k < p.b2);
            if (k == p.drop) bus.enable = 1'b0;
            if (bus.trig) th++;
            if (k == 0) chk("trig_at_ping_start", int'(bus.trig), 1);
            if (k == 999) begin
                chk("busy_in_ping", int'(bus.busy), 1);
                chk("width_hold", int'(bus.width), mw);
            end
        end
        chk("trig_high_cycles", th, 22);
        tick();
    endtask

    initial begin
        int th;
        ping_t p;
        tbl[0] = '{72, 172, -1, -1, -1, 1'b0, 100, 175};   // normal ping
        tbl[1] = '{-1, -1, -1, -1, -1, 1'b1, 0, 622};      // no echo
        tbl[2] = '{25, 30, 100, 140, -1, 1'b0, 40, 143};   // blanked echo then real one
        tbl[3] = '{20, 999, -1, -1, -1, 1'b1, 0, 622};     // already high on entering ARM
        tbl[4] = '{60, 999, -1, -1, -1, 1'b1, 0, 999};     // over-long echo
        tbl[5] = '{619, 629, -1, -1, -1, 1'b0, 10, 632};   // rise on last ARM cycle
        tbl[6] = '{620, 631, -1, -1, -1, 1'b0, 11, 634};   // rise on the timeout cycle
        tbl[7] = '{600, 997, -1, -1, -1, 1'b0, 397, 1000}; // fall on the period boundary
        tbl[8] = '{40, 45, -1, -1, -1, 1'b0, 5, 48};       // ping right after boundary fall
        tbl[9] = '{50, 90, -1, -1, 70, 1'b0, 40, 93};      // enable dropped mid-measure
        bus.enable = 1'b0;
        bus.echo = 1'b0;
        repeat (3) tick();
        chk("reset_trig", int'(bus.trig), 0);
        chk("reset_width", int'(bus.width), 0);
        chk("reset_width_valid", int'(bus.width_valid), 0);
        chk("reset_timeout", int'(bus.timeout), 0);
        chk("reset_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_trig", int'(bus.trig), 0);
        bus.enable = 1'b1;
        tick();
        chk("trig_after_enable", int'(bus.trig), 1);
        for (int i = 0; i < 10; i++) run_ping(tbl[i]);
        chk("busy_after_drop", int'(bus.busy), 0);
        chk("trig_after_drop", int'(bus.trig), 0);
        th = 0;
        repeat (50) begin
            tick();
            th += int'(bus.trig);
        end
        chk("no_trig_after_drop", th, 0);
        bus.enable = 1'b1;
        tick();
        chk("trig_restart", int'(bus.trig), 1);
        for (int k = 1; k <= 100; k++) begin
            tick();
            bus.echo = k >= 48;
        end
        chk("busy_before_reset", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        mw = 0;
        chk("midreset_trig", int'(bus.trig), 0);
        chk("midreset_width", int'(bus.width), 0);
        chk("midreset_width_valid", int'(bus.width_valid), 0);
        chk("midreset_timeout", int'(bus.timeout), 0);
        chk("midreset_busy", int'(bus.busy), 0);
        bus.echo = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("fresh_ping_trig", int'(bus.trig), 1);
        p = '{72, 172, -1, -1, -1, 1'b0, 100, 175};
        run_ping(p);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
